ram_word_bridge: RTL and testbench

RAM_WORD_BRIDGE -- requirements
Module: ram_word_bridge

---
 rtl/ram_word_bridge.sv | 103 ++++++++++
 tb/tb_ram_word_bridge.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ram_word_bridge.sv
// Word-to-byte RAM bridge: splits each 16-bit request into two byte accesses (low, then high)
// on a byte-wide RAM port, each held for WAIT_CYCLES cycles, then strobes a registered response.
module ram_word_bridge #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        accept, last, en_nx, write_nx;
  logic [15:0] addr_q, wdata_q, maddr_nx;
  logic        write_q;
  logic [7:0]  rdata_lo, mwdata_nx;

  // Every output is registered from the next-state values, so the memory port
  // changes on the same edge the state does.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    accept    = 1'b0;
    last      = (cnt == LAST);
    maddr_nx  = mem_addr;
    mwdata_nx = mem_wdata;
    write_nx  = write_q;
    case (state)
      IDLE: if (req_valid) begin
        accept    = 1'b1;
        state_nx  = LO;
        cnt_nx    = '0;
        maddr_nx  = req_addr;
        mwdata_nx = req_wdata[7:0];
        write_nx  = req_write;
      end
      LO: if (last) begin
        state_nx  = HI;
        cnt_nx    = '0;
        maddr_nx  = addr_q + 16'd1;  // wraps 0xFFFF -> 0x0000
        mwdata_nx = wdata_q[15:8];
      end else cnt_nx = cnt + 4'd1;
      HI: if (last) begin
        state_nx = RESP;
        cnt_nx   = '0;
      end else cnt_nx = cnt + 4'd1;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    en_nx = (state_nx == LO) || (state_nx == HI);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      rdata_lo   <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      req_ready  <= (state_nx == IDLE);
      resp_valid <= (state_nx == RESP);
      mem_en     <= en_nx;
      mem_we     <= en_nx & write_nx;
      mem_addr   <= maddr_nx;
      mem_wdata  <= mwdata_nx;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        write_q <= req_write;
      end
      if (state == LO && last && !write_q) rdata_lo <= mem_rdata;
      // Response word only changes on entry to RESP, so it holds between responses.
      if (state == HI && last) resp_rdata <= write_q ? wdata_q : {mem_rdata, rdata_lo};
    end
  end

endmodule

// File: tb/tb_ram_word_bridge.sv
// Self-checking bench for ram_word_bridge: two instances (WAIT_CYCLES 2 and 1), each on its own
// byte RAM, checked cycle by cycle against a byte-array reference model.
module tb_ram_word_bridge;

  logic        clk, reset;
  logic        rv[2], rw[2];
  logic [15:0] ra[2], rd[2];
  logic        rdy[2], rsv[2], men[2], mwe[2];
  logic [15:0] rsd[2], ma[2];
  logic [7:0]  mwd[2], mrd[2];

  bit   [7:0]  ram[2][65536];
  bit   [7:0]  mdl[2][65536];

  logic        bd_we;
  int          bd_k;
  logic [15:0] bd_a;
  logic [7:0]  bd_d;

  int checks = 0;
  int errors = 0;

  ram_word_bridge #(.WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_write(rw[0]), .req_addr(ra[0]),
    .req_wdata(rd[0]), .req_ready(rdy[0]), .resp_valid(rsv[0]), .resp_rdata(rsd[0]),
    .mem_en(men[0]), .mem_we(mwe[0]), .mem_addr(ma[0]), .mem_wdata(mwd[0]), .mem_rdata(mrd[0]));

  ram_word_bridge #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_write(rw[1]), .req_addr(ra[1]),
    .req_wdata(rd[1]), .req_ready(rdy[1]), .resp_valid(rsv[1]), .resp_rdata(rsd[1]),
    .mem_en(men[1]), .mem_we(mwe[1]), .mem_addr(ma[1]), .mem_wdata(mwd[1]), .mem_rdata(mrd[1]));

  always #5 clk = ~clk;

  assign mrd[0] = ram[0][ma[0]];
  assign mrd[1] = ram[1][ma[1]];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (men[k] && mwe[k]) ram[k][ma[k]] <= mwd[k];
    if (bd_we) ram[bd_k][bd_a] <= bd_d;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic poke(input int k, input logic [15:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_k = k; bd_a = a; bd_d = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
    mdl[k][a] = d;
  endtask

  // Entered and left at 1 time unit after a rising edge with instance k idle.
  task automatic txn(input int k, input bit wr, input logic [15:0] a, input logic [15:0] d,
                     input bit junk);
    int          w;
    logic [15:0] a1, exp;
    w  = (k == 0) ? 2 : 1;
    a1 = a + 16'd1;
    chk("ready_idle", rdy[k], 1);
    rv[k] = 1'b1; rw[k] = wr; ra[k] = a; rd[k] = d;
    @(posedge clk); #1;
    if (!junk) rv[k] = 1'b0;
    for (int i = 0; i < 2 * w; i++) begin
      chk("mem_en", men[k], 1);
      chk("mem_we", mwe[k], wr);
      chk("mem_addr", ma[k], (i < w) ? a : a1);
      chk("mem_wdata", mwd[k], (i < w) ? d[7:0] : d[15:8]);
      chk("busy_ready", rdy[k], 0);
      chk("early_resp", rsv[k], 0);
      if (junk) begin
        rw[k] = 1'($urandom); ra[k] = 16'($urandom); rd[k] = 16'($urandom);
      end
      @(posedge clk); #1;
    end
    exp = wr ? d : {mdl[k][a1], mdl[k][a]};
    if (wr) begin
      mdl[k][a]  = d[7:0];
      mdl[k][a1] = d[15:8];
    end
    chk("resp_valid", rsv[k], 1);
    chk("resp_men", men[k], 0);
    chk("resp_mwe", mwe[k], 0);
    chk("resp_rdata", rsd[k], exp);
    if (junk) begin
      rw[k] = 1'($urandom); ra[k] = 16'($urandom); rd[k] = 16'($urandom);
    end
    @(posedge clk); #1;
    chk("resp_pulse", rsv[k], 0);
    chk("ready_after", rdy[k], 1);
    chk("rdata_hold", rsd[k], exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clk = 1'b0; reset = 1'b1; bd_we = 1'b0; bd_k = 0; bd_a = '0; bd_d = '0;
    for (int k = 0; k < 2; k++) begin
      rv[k] = 1'b0; rw[k] = 1'b0; ra[k] = '0; rd[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", rdy[0], 1);
    chk("rst_resp", rsv[0], 0);
    chk("rst_rdata", rsd[0], 16'h0000);
    chk("rst_men", men[0], 0);
    chk("rst_mwe", mwe[0], 0);
    chk("rst_maddr", ma[0], 16'h0000);
    chk("rst_mwdata", mwd[0], 8'h00);

    poke(0, 16'h1234, 8'hCD);
    poke(0, 16'h1235, 8'hAB);
    poke(0, 16'hFFFF, 8'h11);
    poke(0, 16'h0000, 8'h22);
    poke(1, 16'h1234, 8'hCD);
    poke(1, 16'h1235, 8'hAB);
    reset = 1'b0;

    txn(0, 1'b0, 16'h1234, 16'h0000, 1'b0);
    chk("read_word", rsd[0], 16'hABCD);
    txn(0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    chk("wr_lo_byte", ram[0][16'h0010], 8'hEF);
    chk("wr_hi_byte", ram[0][16'h0011], 8'hBE);
    chk("wr_resp", rsd[0], 16'hBEEF);
    txn(0, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
    chk("wrap_word", rsd[0], 16'h2211);

    // Busy: req_valid stays high with random traffic; next request taken right after RESP.
    txn(0, 1'b0, 16'h1234, 16'h0000, 1'b1);
    txn(0, 1'b1, 16'h2000, 16'h5A5A, 1'b0);
    chk("busy_second", ram[0][16'h2001], 8'h5A);

    // Reset during HI of a write to 0x0040.
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 16'h0040; rd[0] = 16'h1357;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("hi_addr", ma[0], 16'h0041);
    reset = 1'b1;
    #1;
    chk("abort_men", men[0], 0);
    chk("abort_mwe", mwe[0], 0);
    chk("abort_resp", rsv[0], 0);
    chk("abort_ready", rdy[0], 1);
    mdl[0][16'h0040] = 8'h57;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_lo_written", ram[0][16'h0040], 8'h57);
    chk("abort_hi_kept", ram[0][16'h0041], mdl[0][16'h0041]);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_resp", rsv[0], 0);
    end
    txn(0, 1'b0, 16'h0040, 16'h0000, 1'b0);

    txn(1, 1'b0, 16'h1234, 16'h0000, 1'b0);
    chk("w1_read", rsd[1], 16'hABCD);

    for (int n = 0; n < 60; n++) begin
      int          k;
      logic [15:0] a;
      k = int'($urandom_range(0, 1));
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'(16'h0100 + $urandom_range(0, 63));
      txn(k, 1'($urandom), a, 16'($urandom), 1'($urandom));
      rv[0] = 1'b0; rv[1] = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
